// File: rtl/dmem_host_port.sv
// Host-side load/dump port for the CPU data memory. It streams host words into
// memory (LOAD) and reads a region back out (DUMP_RD/DUMP_OUT), owning the memory via cpu_hold.
module dmem_host_port #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start_load,
  input  logic          start_dump,
  input  logic [AW-1:0] base_addr,
  input  logic [AW-1:0] length,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  input  logic          cpu_done,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  output logic          mem_re,
  input  logic [DW-1:0] mem_rdata,
  output logic          cpu_hold,
  output logic          busy,
  output logic          load_done,
  output logic          dump_done,
  output logic [1:0]    dbg_state
);

  // Handshakes: a word moves on in_valid&in_ready (host->memory) or on
  // out_valid&out_ready (memory->host); the producer holds its data until then.
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_LOAD     = 2'd1;
  localparam logic [1:0] ST_DUMP_RD  = 2'd2;
  localparam logic [1:0] ST_DUMP_OUT = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic          fresh_q, fresh_d;
  logic          hold_q, hold_d;
  logic          load_done_q, load_done_d;
  logic          dump_done_q, dump_done_d;
  logic [AW:0]   start_cnt;
  logic          last_beat;
  logic          cpu_done_unused;

  assign cpu_done_unused = cpu_done;

  // A length of zero encodes a full 2^AW-word burst.
  assign start_cnt = (length == '0) ? {1'b1, {AW{1'b0}}} : {1'b0, length};
  assign last_beat = (cnt_q == (AW+1)'(1));

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    fresh_d     = 1'b0;
    hold_d      = hold_q;
    load_done_d = 1'b0;
    dump_done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_load) begin
          state_d = ST_LOAD;
          ptr_d   = base_addr;
          cnt_d   = start_cnt;
          hold_d  = 1'b1;
        end else if (start_dump) begin
          state_d = ST_DUMP_RD;
          ptr_d   = base_addr;
          cnt_d   = start_cnt;
          hold_d  = 1'b1;
        end
      end
      ST_LOAD: begin
        if (in_valid) begin
          ptr_d = ptr_q + AW'(1);
          cnt_d = cnt_q - (AW+1)'(1);
          if (last_beat) begin
            state_d     = ST_IDLE;
            load_done_d = 1'b1;
            hold_d      = 1'b0;
          end
        end
      end
      ST_DUMP_RD: begin
        state_d = ST_DUMP_OUT;
        fresh_d = 1'b1;
      end
      ST_DUMP_OUT: begin
        // Read data arrives in the first DUMP_OUT cycle; capture it so the
        // word stays stable however long the host stalls.
        if (fresh_q) out_data_d = mem_rdata;
        if (out_ready) begin
          ptr_d = ptr_q + AW'(1);
          cnt_d = cnt_q - (AW+1)'(1);
          if (last_beat) begin
            state_d     = ST_IDLE;
            dump_done_d = 1'b1;
          end else begin
            state_d = ST_DUMP_RD;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      fresh_q     <= 1'b0;
      hold_q      <= 1'b1;
      load_done_q <= 1'b0;
      dump_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      fresh_q     <= fresh_d;
      hold_q      <= hold_d;
      load_done_q <= load_done_d;
      dump_done_q <= dump_done_d;
    end
  end

  assign in_ready  = (state_q == ST_LOAD);
  assign mem_we    = (state_q == ST_LOAD) && in_valid;
  assign mem_re    = (state_q == ST_DUMP_RD);
  assign mem_addr  = (mem_we || mem_re) ? ptr_q : '0;
  assign mem_wdata = mem_we ? in_data : '0;
  assign out_valid = (state_q == ST_DUMP_OUT);
  assign out_data  = fresh_q ? mem_rdata : out_data_q;
  assign cpu_hold  = hold_q;
  assign busy      = (state_q != ST_IDLE);
  assign load_done = load_done_q;
  assign dump_done = dump_done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_dmem_host_port.sv
// Randomized scoreboard bench for dmem_host_port with a behavioural data memory
// and a reference memory image updated from the burst rules.
module tb_dmem_host_port;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_load, start_dump;
  logic [7:0] base_addr, length;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       cpu_done;
  logic [7:0] mem_addr, mem_wdata;
  logic       mem_we, mem_re;
  logic [7:0] mem_rdata;
  logic       cpu_hold, busy, load_done, dump_done;
  logic [1:0] dbg_state;

  dmem_host_port #(.AW(8), .DW(8)) dut (
    .clk(clk), .reset(reset), .start_load(start_load), .start_dump(start_dump),
    .base_addr(base_addr), .length(length), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .cpu_done(cpu_done), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_re(mem_re), .mem_rdata(mem_rdata), .cpu_hold(cpu_hold), .busy(busy),
    .load_done(load_done), .dump_done(dump_done), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // behavioural synchronous data memory
  logic [7:0] ram [0:255];
  logic [7:0] rdata_q;
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_re) rdata_q <= ram[mem_addr];
  end
  assign mem_rdata = rdata_q;

  // reference model and scoreboard state
  logic [7:0]  ref_mem [0:255];
  logic [7:0]  load_data [0:255];
  logic [15:0] exp_wq[$];
  logic [7:0]  exp_rq[$];
  logic [7:0]  exp_oq[$];
  int vectors = 0;
  int miscompares = 0;
  int re_cnt = 0, wr_cnt = 0, ld_cnt = 0, dd_cnt = 0;
  logic       held = 1'b0;
  logic [7:0] held_data = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: pops expectations whenever the DUT presents a memory or output beat
  always @(negedge clk) begin
    if (reset) begin
      check("we_re_excl", {31'd0, mem_we & mem_re}, 32'd0);
      if (load_done) ld_cnt++;
      if (dump_done) dd_cnt++;
      if (mem_we) begin
        wr_cnt++;
        if (exp_wq.size() == 0) check("unexp_write", 1, 0);
        else begin
          logic [15:0] e;
          e = exp_wq.pop_front();
          check("wr_addr", {24'd0, mem_addr}, {24'd0, e[15:8]});
          check("wr_data", {24'd0, mem_wdata}, {24'd0, e[7:0]});
        end
      end
      if (mem_re) begin
        re_cnt++;
        if (exp_rq.size() == 0) check("unexp_read", 1, 0);
        else check("rd_addr", {24'd0, mem_addr}, {24'd0, exp_rq.pop_front()});
      end
      if (out_valid && !out_ready) begin
        if (held) check("out_stable", {24'd0, out_data}, {24'd0, held_data});
        held = 1'b1;
        held_data = out_data;
      end else if (out_valid && out_ready) begin
        if (held) check("out_stable", {24'd0, out_data}, {24'd0, held_data});
        held = 1'b0;
        if (exp_oq.size() == 0) check("unexp_out", 1, 0);
        else check("out_data", {24'd0, out_data}, {24'd0, exp_oq.pop_front()});
      end else begin
        held = 1'b0;
      end
    end
  end

  // driver: mode 0 = in_valid always, 1 = toggling 1,0,1,0, 2 = random
  task automatic load_burst(input logic [7:0] base, input logic [7:0] len, input int mode,
                            input bit both, input int stop_after);
    int n, sent, cyc;
    logic v;
    logic [7:0] a;
    n = (len == 0) ? 256 : int'(len);
    sent = 0;
    cyc = 0;
    start_load = 1'b1;
    start_dump = both;
    base_addr = base;
    length = len;
    @(posedge clk); #1;
    start_load = 1'b0;
    start_dump = 1'b0;
    while (sent < n && sent < stop_after && cyc < 2000) begin
      if (mode == 0) v = 1'b1;
      else if (mode == 1) v = (cyc % 2 == 0);
      else v = ($urandom_range(0, 3) != 0);
      in_valid = v;
      if (v) begin
        a = base + sent[7:0];
        in_data = load_data[sent];
        exp_wq.push_back({a, load_data[sent]});
        ref_mem[a] = load_data[sent];
      end else begin
        in_data = 8'($urandom);
      end
      @(negedge clk);
      if (v) check("in_ready", {31'd0, in_ready}, 1);
      check("hold_in_load", {31'd0, cpu_hold}, 1);
      @(posedge clk); #1;
      if (v) sent++;
      cyc++;
    end
    in_valid = 1'b0;
    if (cyc >= 2000) check("load_timeout", 1, 0);
    else if (sent == n) begin
      check("load_done", {31'd0, load_done}, 1);
      check("hold_after_load", {31'd0, cpu_hold}, 0);
      check("busy_after_load", {31'd0, busy}, 0);
      if (mode == 0) check("load_cycles", cyc, n);
      @(posedge clk); #1;
      check("load_done_pulse", {31'd0, load_done}, 0);
    end
  endtask

  task automatic dump_burst(input logic [7:0] base, input logic [7:0] len, input int stall_beat,
                            input int stall_len, input bit rnd);
    int n, beats, cyc, stalled;
    logic acc;
    n = (len == 0) ? 256 : int'(len);
    for (int i = 0; i < n; i++) begin
      logic [7:0] a;
      a = base + i[7:0];
      exp_rq.push_back(a);
      exp_oq.push_back(ref_mem[a]);
    end
    re_cnt = 0;
    beats = 0;
    cyc = 0;
    stalled = 0;
    start_dump = 1'b1;
    base_addr = base;
    length = len;
    @(posedge clk); #1;
    start_dump = 1'b0;
    while (beats < n && cyc < 2000) begin
      if (beats == stall_beat && out_valid && stalled < stall_len) begin
        out_ready = 1'b0;
        stalled++;
      end else if (rnd) out_ready = ($urandom_range(0, 2) != 0);
      else out_ready = 1'b1;
      @(negedge clk);
      acc = out_valid && out_ready;
      check("hold_in_dump", {31'd0, cpu_hold}, 1);
      @(posedge clk); #1;
      if (acc) beats++;
      cyc++;
    end
    out_ready = 1'b0;
    if (cyc >= 2000) check("dump_timeout", 1, 0);
    else begin
      check("dump_done", {31'd0, dump_done}, 1);
      check("out_valid_end", {31'd0, out_valid}, 0);
      check("hold_after_dump", {31'd0, cpu_hold}, 1);
      check("busy_after_dump", {31'd0, busy}, 0);
      check("dump_reads", re_cnt, n);
      if (stall_len == 0 && !rnd) check("dump_cycles", cyc, 2 * n);
      @(posedge clk); #1;
      check("dump_done_pulse", {31'd0, dump_done}, 0);
    end
  endtask

  task automatic check_ram(input string name);
    int bad;
    bad = 0;
    for (int i = 0; i < 256; i++) if (ram[i] !== ref_mem[i]) bad++;
    check(name, bad, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i] = 8'h00;
      ref_mem[i] = 8'h00;
    end
    reset = 1'b0;
    start_load = 1'b0; start_dump = 1'b0;
    base_addr = 8'h00; length = 8'h00;
    in_data = 8'h00; in_valid = 1'b0; out_ready = 1'b0;
    cpu_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 0);
    check("rst_out_valid", {31'd0, out_valid}, 0);
    check("rst_mem_we", {31'd0, mem_we}, 0);
    check("rst_mem_re", {31'd0, mem_re}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_cpu_hold", {31'd0, cpu_hold}, 1);
    check("rst_mem_addr", {24'd0, mem_addr}, 0);
    check("rst_out_data", {24'd0, out_data}, 0);
    check("rst_state", {30'd0, dbg_state}, 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;

    // contiguous load 0x10..0x13 with A1..A4
    for (int i = 0; i < 4; i++) load_data[i] = 8'hA1 + 8'(i);
    ld_cnt = 0;
    load_burst(8'h10, 8'd4, 0, 1'b0, 256);
    check("load_done_count", ld_cnt, 1);

    // load with in_valid toggling
    for (int i = 0; i < 4; i++) load_data[i] = 8'($urandom);
    wr_cnt = 0;
    load_burst(8'h20, 8'd4, 1, 1'b0, 256);
    check("toggle_writes", wr_cnt, 4);

    // wrap-around dump FE,FF,00,01
    load_data[0] = 8'h11; load_data[1] = 8'h22; load_data[2] = 8'h33; load_data[3] = 8'h44;
    load_burst(8'hFE, 8'd4, 0, 1'b0, 256);
    dd_cnt = 0;
    dump_burst(8'hFE, 8'd4, 999, 0, 1'b0);
    check("dump_done_count", dd_cnt, 1);

    // host stalls the second word for 5 cycles
    dump_burst(8'h10, 8'd4, 1, 5, 1'b0);

    // both starts together, full 256-word load
    for (int i = 0; i < 256; i++) load_data[i] = 8'($urandom);
    re_cnt = 0;
    wr_cnt = 0;
    load_burst(8'($urandom), 8'd0, 0, 1'b1, 256);
    repeat (4) @(posedge clk);
    #1;
    check("both_no_reads", re_cnt, 0);
    check("both_writes", wr_cnt, 256);
    check("both_idle", {31'd0, busy}, 0);
    check_ram("ram_after_full");

    // random bursts, with cpu_done wiggling to show it is ignored
    for (int k = 0; k < 8; k++) begin
      logic [7:0] b, l;
      b = 8'($urandom);
      l = 8'($urandom_range(1, 24));
      cpu_done = 1'($urandom);
      for (int i = 0; i < 24; i++) load_data[i] = 8'($urandom);
      load_burst(b, l, 2, 1'b0, 256);
      dump_burst(8'($urandom), 8'($urandom_range(1, 24)), $urandom_range(0, 5),
                 $urandom_range(0, 4), 1'b1);
    end
    check_ram("ram_after_random");

    // reset after 2 of 4 load beats
    load_data[0] = 8'h5A; load_data[1] = 8'hC3; load_data[2] = 8'h77; load_data[3] = 8'h88;
    load_burst(8'h40, 8'd4, 0, 1'b0, 2);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_in_ready", {31'd0, in_ready}, 0);
    check("mid_rst_mem_we", {31'd0, mem_we}, 0);
    check("mid_rst_busy", {31'd0, busy}, 0);
    check("mid_rst_cpu_hold", {31'd0, cpu_hold}, 1);
    check("mid_rst_load_done", {31'd0, load_done}, 0);
    check("mid_rst_mem_addr", {24'd0, mem_addr}, 0);
    check("mid_rst_wdata", {24'd0, mem_wdata}, 0);
    check("mid_rst_ram40", {24'd0, ram[8'h40]}, 32'h5A);
    check("mid_rst_ram41", {24'd0, ram[8'h41]}, 32'hC3);
    check("mid_rst_wq_empty", exp_wq.size(), 0);
    exp_wq.delete();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("post_rst_busy", {31'd0, busy}, 0);
    check("post_rst_hold", {31'd0, cpu_hold}, 1);
    check_ram("ram_final");
    check("out_q_empty", exp_oq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dmem_host_port.md
Name: dmem_host_port

Overview:
- Host-side writer/reader for the CPU's 8-bit data memory, the other end of the CPU's load/store path.
- Before a run it streams bytes from a host or bench into data memory over a valid/ready handshake, holding the CPU stalled.
- After the CPU raises done, it reads a region back out over a second valid/ready stream.
- Sits beside data_mem. A top-level mux gives this block the memory port whenever cpu_hold=1.

Parameters:
AW, 8, data memory address width; addresses wrap modulo 2^AW
DW, 8, data word width

Ports:
clk  in  1  clock; all state changes on rising edge
reset  in  1  asynchronous, active-low reset
start_load  in  1  pulse; begin load burst (accepted only in IDLE)
start_dump  in  1  pulse; begin dump burst (accepted only in IDLE)
base_addr  in  AW  first memory address of burst; sampled at start
length  in  AW  burst length in words; 0 means 2^AW (256); sampled at start
in_data  in  DW  host write data
in_valid  in  1  host write data valid
in_ready  out  1  block accepts in_data this cycle
out_data  out  DW  dumped word
out_valid  out  1  out_data valid
out_ready  in  1  host accepts out_data
cpu_done  in  1  CPU done flag, status only
mem_addr  out  AW  data memory address
mem_wdata  out  DW  data memory write data
mem_we  out  1  data memory write enable
mem_re  out  1  data memory read enable
mem_rdata  in  DW  data memory read data, valid the cycle after mem_re
cpu_hold  out  1  1 = CPU stalled and memory owned by this block
busy  out  1  1 whenever state is not IDLE
load_done  out  1  one-cycle pulse after the last load beat
dump_done  out  1  one-cycle pulse after the last dump beat is accepted

Behaviour:
- Reset (async, while reset=0) forces the following; partial writes already done to memory are not undone:
  - state=IDLE, ptr=0, cnt=0;
  - in_ready, out_valid, mem_we, mem_re, busy, load_done and dump_done all 0;
  - out_data, mem_addr and mem_wdata all 0;
  - cpu_hold=1.
- States: IDLE, LOAD, DUMP_RD, DUMP_OUT.
- IDLE:
  - start_load moves to LOAD: ptr=base_addr, cnt=length, where 0 means 256.
  - start_dump moves to DUMP_RD with the same sampling, and sets cpu_hold=1.
  - If both starts are asserted in the same cycle, start_load wins and start_dump is dropped.
  - Starts asserted outside IDLE are ignored.
- LOAD:
  - in_ready=1.
  - On in_valid & in_ready, combinationally in the same cycle: mem_we=1, mem_addr=ptr, mem_wdata=in_data.
  - Then ptr=ptr+1 mod 2^AW and cnt=cnt-1.
  - On the beat where cnt=1: go to IDLE, load_done=1 for the next cycle, cpu_hold=0 from the next cycle.
  - in_valid=0 inserts bubbles with no state change.
- DUMP_RD: mem_re=1, mem_addr=ptr for exactly one cycle, then go to DUMP_OUT.
- DUMP_OUT:
  - On entry, out_data is registered from mem_rdata and out_valid=1.
  - out_data is held stable until out_ready.
  - On out_valid & out_ready: ptr++ and cnt--. If the beat was the last one, go to IDLE, out_valid=0 and dump_done pulses; otherwise go back to DUMP_RD.
  - Throughput is 1 word per 2 cycles when out_ready is held high.
- cpu_hold stays 1 through a dump and after it; only a completed load clears it.
- mem_we and mem_re are never both 1. Both are 0 in IDLE.
- Address wrap: a burst crossing 0xFF continues at 0x00.
- A 256-word burst touches every address exactly once.
- cpu_done has no effect on the state machine; a host may dump at any time.

Test Plan:
- Reset release, then start_load, base=0x10, len=4, in_data 0xA1..0xA4 with in_valid always high -> mem_we on 4 consecutive cycles at 0x10..0x13; load_done pulses once; cpu_hold falls the next cycle.
- Load with in_valid toggling 1,0,1,0 -> writes only on valid cycles; addresses stay contiguous; count is exact.
- start_dump, base=0xFE, len=4, memory preloaded FE=11, FF=22, 00=33, 01=44, out_ready=1 -> out_data sequence 11,22,33,44; mem_addr wraps FE,FF,00,01; dump_done pulses once.
- Dump with out_ready held low 5 cycles on the second word -> out_valid stays 1, out_data stays stable, no extra mem_re issued.
- start_load and start_dump in the same cycle, len=0 -> LOAD only; exactly 256 writes; dump never starts.
- reset asserted after 2 of 4 load beats -> all outputs immediately at reset values; cpu_hold=1; memory keeps the 2 written bytes.
